// File: rtl/fifo_merge_arbiter_pkg.sv
// Shared types and helpers for the FIFO merge arbiter: lock-state encoding,
// priority-mode constants and the clog2 used to size pointer and burst counter.
package fifo_merge_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } lock_state_t;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < value) ? i + 1 : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_merge_arbiter_rotating_prio_enc.sv
// Rotating priority encoder: first set request at or after base (wrapping at
// N_CH-1 -> 0), or lowest set request when fixed is high.
module rotating_prio_enc
  import fifo_merge_arbiter_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int PTR_W = 3
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] base,
  input  logic             fixed,
  output logic [N_CH-1:0]  grant,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  logic [PTR_W-1:0] start_s;
  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] pos_s;

  // scan offsets from far to near so the nearest requester is written last
  always_comb begin
    start_s = fixed ? '0 : base;
    sum_s   = '0;
    pos_s   = '0;
    idx     = '0;
    valid   = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      sum_s = {1'b0, start_s} + (PTR_W+1)'(k);
      pos_s = (sum_s >= (PTR_W+1)'(N_CH)) ? PTR_W'(sum_s - (PTR_W+1)'(N_CH))
                                           : sum_s[PTR_W-1:0];
      idx   = req[pos_s] ? pos_s : idx;
      valid = valid | req[pos_s];
    end
    grant = valid ? (N_CH'(1) << idx) : '0;
  end

endmodule

// File: rtl/fifo_merge_arbiter.sv
// N-channel round-robin / fixed-priority merger of FWFT FIFOs with burst lock and
// a registered output word. Optional per-channel counters: FIFO_MERGE_WORD_CNT_EN.
module fifo_merge_arbiter
  import fifo_merge_arbiter_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic                   BUS_CLK,
  input  logic                   BUS_RST,
  input  logic [N_CH-1:0]        WRITE_REQ,
  input  logic [N_CH-1:0]        HOLD_REQ,
  input  logic [N_CH*DATA_W-1:0] DATA_IN,
  input  logic [N_CH-1:0]        CH_EN,
  input  logic                   PRIO_MODE,
  output logic [N_CH-1:0]        READ_GRANT,
  input  logic                   READY_OUT,
  output logic                   WRITE_OUT,
  output logic [DATA_W-1:0]      DATA_OUT,
  output logic                   LOCKED,
  input  logic                   CNT_CLR,
  output logic [N_CH*CNT_W-1:0]  WORD_CNT
);

  localparam int PTR_W = clog2(N_CH);
  localparam int BW    = clog2(MAX_BURST + 1);

  lock_state_t       lock_st_r, lock_nx_s;
  logic [PTR_W-1:0]  lock_ch_r, lock_ch_nx_s;
  logic [BW-1:0]     burst_r, burst_nx_s, burst_inc_s;
  logic [PTR_W-1:0]  rr_ptr_r, rr_nx_s;
  logic              write_out_r;
  logic [DATA_W-1:0] data_out_r;

  logic [N_CH-1:0]   eligible_s, enc_grant_s;
  logic [PTR_W-1:0]  enc_idx_s, win_idx_s;
  logic              enc_valid_s, slot_free_s, lock_win_s, grant_v_s;
  logic              start_s, start_lock_s, start_ptr_s;
  logic [DATA_W-1:0] win_data_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_CH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign eligible_s  = WRITE_REQ & CH_EN;
  assign slot_free_s = ~write_out_r | READY_OUT;
  assign burst_inc_s = burst_r + BW'(1);

  rotating_prio_enc #(.N_CH(N_CH), .PTR_W(PTR_W)) u_enc (
    .req   (eligible_s),
    .base  (rr_ptr_r),
    .fixed (PRIO_MODE == PRIO_FIXED),
    .grant (enc_grant_s),
    .idx   (enc_idx_s),
    .valid (enc_valid_s)
  );

  // winner selection; the lock overrides both arbitration modes; no pops in reset
  always_comb begin
    lock_win_s = (lock_st_r == ST_LOCK) && eligible_s[lock_ch_r];
    grant_v_s  = slot_free_s && enc_valid_s && !BUS_RST;
    win_idx_s  = lock_win_s ? lock_ch_r : enc_idx_s;
    READ_GRANT = !grant_v_s ? '0 : (lock_win_s ? (N_CH'(1) << lock_ch_r) : enc_grant_s);
    win_data_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      win_data_s = (win_idx_s == PTR_W'(i)) ? DATA_IN[i*DATA_W +: DATA_W] : win_data_s;
    end
  end

  // lock FSM, burst counter and rr pointer next state
  always_comb begin
    lock_nx_s    = lock_st_r;
    lock_ch_nx_s = lock_ch_r;
    burst_nx_s   = burst_r;
    rr_nx_s      = rr_ptr_r;
    start_s      = 1'b0;
    case (lock_st_r)
      ST_LOCK: begin
        if (grant_v_s && lock_win_s) begin
          if (!HOLD_REQ[lock_ch_r] || (burst_inc_s >= BW'(MAX_BURST))) begin
            lock_nx_s  = ST_IDLE;
            burst_nx_s = '0;
            rr_nx_s    = ptr_inc(lock_ch_r);
          end else begin
            burst_nx_s = burst_inc_s;
          end
        end else if (!HOLD_REQ[lock_ch_r] || !CH_EN[lock_ch_r] || grant_v_s) begin
          // a grant here went to another channel: it arbitrates as from idle
          lock_nx_s  = ST_IDLE;
          burst_nx_s = '0;
          start_s    = grant_v_s;
        end else begin
          lock_nx_s = ST_LOCK;
        end
      end
      ST_IDLE: begin
        start_s = grant_v_s;
      end
      default: begin
        lock_nx_s  = ST_IDLE;
        burst_nx_s = '0;
      end
    endcase
    start_lock_s = start_s && HOLD_REQ[win_idx_s] && (MAX_BURST > 1);
    start_ptr_s  = start_s && !start_lock_s;
    lock_nx_s    = start_lock_s ? ST_LOCK : lock_nx_s;
    lock_ch_nx_s = start_lock_s ? win_idx_s : lock_ch_nx_s;
    burst_nx_s   = start_lock_s ? BW'(1) : burst_nx_s;
    rr_nx_s      = start_ptr_s ? ptr_inc(win_idx_s) : rr_nx_s;
  end

  // arbitration state registers
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      lock_st_r <= ST_IDLE;
      lock_ch_r <= '0;
      burst_r   <= '0;
      rr_ptr_r  <= '0;
    end else begin
      lock_st_r <= lock_nx_s;
      lock_ch_r <= lock_ch_nx_s;
      burst_r   <= burst_nx_s;
      rr_ptr_r  <= rr_nx_s;
    end
  end

  // one-word output stage
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      write_out_r <= 1'b0;
      data_out_r  <= '0;
    end else if (grant_v_s) begin
      write_out_r <= 1'b1;
      data_out_r  <= win_data_s;
    end else if (READY_OUT) begin
      write_out_r <= 1'b0;
    end
  end

  assign WRITE_OUT = write_out_r;
  assign DATA_OUT  = data_out_r;
  assign LOCKED    = (lock_st_r == ST_LOCK);

`ifdef FIFO_MERGE_WORD_CNT_EN
  logic [N_CH*CNT_W-1:0] word_cnt_r;

  // saturating per-channel grant counters; clear beats a same-cycle grant
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      word_cnt_r <= '0;
    end else if (CNT_CLR) begin
      word_cnt_r <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (READ_GRANT[i] && (word_cnt_r[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          word_cnt_r[i*CNT_W +: CNT_W] <= word_cnt_r[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign WORD_CNT = word_cnt_r;
`else
  logic unused_cnt_clr_s;
  assign unused_cnt_clr_s = CNT_CLR;
  assign WORD_CNT         = '0;
`endif

endmodule
